// File: rtl/mmio_slot_bridge.sv
// Processor MMIO bridge: splits the data bus between DMEM and a bank of coprocessor slots,
// each with a frame snapshot, live readback, read-to-clear status and a control register.
module mmio_slot_bridge #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned SLOT_BITS = 5,
   parameter int unsigned WORD_BITS = 7,
   localparam int unsigned NUM_SLOTS = 2 ** SLOT_BITS
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [ADDR_W-1:0]           address,
   input  logic [DATA_W-1:0]           data_in,
   input  logic                        wren,
   input  logic                        rden,
   output logic [DATA_W-1:0]           data_out,
   output logic                        rvalid,
   input  logic                        snap,
   input  logic [NUM_SLOTS*DATA_W-1:0] slot_in,
   output logic [NUM_SLOTS*DATA_W-1:0] slot_ctrl,
   output logic [NUM_SLOTS-1:0]        ctrl_wstrobe,
   output logic [ADDR_W-2:0]           dmem_address,
   output logic [DATA_W-1:0]           dmem_data,
   output logic                        dmem_wren,
   input  logic [DATA_W-1:0]           dmem_q
);

   logic                              sel_mmio;
   logic [SLOT_BITS-1:0]              slot;
   logic [1:0]                        word;
   logic                              hole;
   logic                              ctrl_wr;
   logic                              status_rd;

   logic [NUM_SLOTS-1:0][DATA_W-1:0]  live;
   logic [NUM_SLOTS-1:0][DATA_W-1:0]  snap_q;
   logic [NUM_SLOTS-1:0][DATA_W-1:0]  ctrl_q;
   logic [NUM_SLOTS-1:0]              changed_q, changed_d;
   logic [NUM_SLOTS-1:0]              overrun_q, overrun_d;
   logic [NUM_SLOTS-1:0]              clear_vec, event_vec;
   logic [NUM_SLOTS-1:0]              strobe_q;
   logic [DATA_W-1:0]                 rd_val;
   logic [DATA_W-1:0]                 rdata_q;
   logic                              rvalid_q;

   assign sel_mmio  = address[ADDR_W-1];
   assign slot      = address[ADDR_W-2:WORD_BITS];
   assign word      = address[1:0];
   assign hole      = |address[WORD_BITS-1:2];
   assign ctrl_wr   = wren & sel_mmio & ~hole & (word == 2'd3);
   assign status_rd = rden & sel_mmio & ~hole & (word == 2'd2);

   assign live         = slot_in;
   assign slot_ctrl    = ctrl_q;
   assign ctrl_wstrobe = strobe_q;
   assign data_out     = rdata_q;
   assign rvalid       = rvalid_q;

   assign dmem_address = address[ADDR_W-2:0];
   assign dmem_data    = data_in;
   assign dmem_wren    = wren & ~sel_mmio;

   always_comb begin
      rd_val = '0;
      if (!sel_mmio) begin
         rd_val = dmem_q;
      end else if (!hole) begin
         case (word)
            2'd0:    rd_val = snap_q[slot];
            2'd1:    rd_val = live[slot];
            2'd2:    rd_val = DATA_W'({overrun_q[slot], changed_q[slot]});
            default: rd_val = ctrl_q[slot];
         endcase
      end
   end

   always_comb begin
      clear_vec = '0;
      event_vec = '0;
      if (status_rd) clear_vec[slot] = 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         event_vec[i] = snap && (live[i] != snap_q[i]);
      end
      // An event racing a clear survives, but only history that escaped the clear counts as overrun.
      changed_d = (changed_q & ~clear_vec) | event_vec;
      overrun_d = (overrun_q & ~clear_vec) | (event_vec & changed_q & ~clear_vec);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         snap_q    <= '0;
         ctrl_q    <= '0;
         changed_q <= '0;
         overrun_q <= '0;
         strobe_q  <= '0;
      end else begin
         rvalid_q  <= rden;
         if (rden) rdata_q <= rd_val;
         if (snap) snap_q <= live;
         changed_q <= changed_d;
         overrun_q <= overrun_d;
         strobe_q  <= '0;
         if (ctrl_wr) begin
            ctrl_q[slot]   <= data_in;
            strobe_q[slot] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mmio_slot_bridge.sv
// Self-checking bench for mmio_slot_bridge: directed scenarios plus random traffic
// compared against a behavioural register-map model.
module tb_mmio_slot_bridge;

   localparam int NS = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic [12:0]       address;
   logic [31:0]       data_in;
   logic              wren;
   logic              rden;
   logic [31:0]       data_out;
   logic              rvalid;
   logic              snap;
   logic [NS-1:0][31:0] slot_in_p;
   logic [NS-1:0][31:0] slot_ctrl_p;
   logic [NS-1:0]     ctrl_wstrobe;
   logic [11:0]       dmem_address;
   logic [31:0]       dmem_data;
   logic              dmem_wren;
   logic [31:0]       dmem_q;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [31:0] m_snap [NS];
   logic [31:0] m_ctrl [NS];
   bit          m_chg  [NS];
   bit          m_ovr  [NS];
   logic [31:0] m_rdata;
   bit          m_rvalid;
   logic [31:0] m_strobe;

   mmio_slot_bridge dut (
      .clock        (clock),
      .reset        (reset),
      .address      (address),
      .data_in      (data_in),
      .wren         (wren),
      .rden         (rden),
      .data_out     (data_out),
      .rvalid       (rvalid),
      .snap         (snap),
      .slot_in      (slot_in_p),
      .slot_ctrl    (slot_ctrl_p),
      .ctrl_wstrobe (ctrl_wstrobe),
      .dmem_address (dmem_address),
      .dmem_data    (dmem_data),
      .dmem_wren    (dmem_wren),
      .dmem_q       (dmem_q)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < NS; i++) begin
         m_snap[i] = '0;
         m_ctrl[i] = '0;
         m_chg[i]  = 1'b0;
         m_ovr[i]  = 1'b0;
      end
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_strobe = '0;
   endfunction

   // One bus cycle: drive, check passthrough, advance model, check registered outputs.
   task automatic step(input logic [12:0] a, input logic [31:0] d, input bit w, input bit r,
                       input bit s);
      bit          mmio, hole, clr, prev;
      int          sl, wd;
      address = a;
      data_in = d;
      wren    = w;
      rden    = r;
      snap    = s;
      #1;
      check("dmem_address", 32'(dmem_address), 32'(a[11:0]));
      check("dmem_data", dmem_data, d);
      check("dmem_wren", 32'(dmem_wren), 32'(w && !a[12]));
      mmio = a[12];
      sl   = int'(a[11:7]);
      wd   = int'(a[1:0]);
      hole = (a[6:2] != 0);
      m_rvalid = r;
      if (r) begin
         if (!mmio)      m_rdata = dmem_q;
         else if (hole)  m_rdata = 0;
         else if (wd == 0) m_rdata = m_snap[sl];
         else if (wd == 1) m_rdata = slot_in_p[sl];
         else if (wd == 2) m_rdata = {30'd0, m_ovr[sl], m_chg[sl]};
         else            m_rdata = m_ctrl[sl];
      end
      m_strobe = '0;
      if (w && mmio && !hole && wd == 3) begin
         m_ctrl[sl]   = d;
         m_strobe[sl] = 1'b1;
      end
      for (int i = 0; i < NS; i++) begin
         clr  = r && mmio && !hole && wd == 2 && sl == i;
         prev = clr ? 1'b0 : m_chg[i];
         if (clr) begin
            m_chg[i] = 1'b0;
            m_ovr[i] = 1'b0;
         end
         if (s && slot_in_p[i] != m_snap[i]) begin
            if (prev) m_ovr[i] = 1'b1;
            m_chg[i]  = 1'b1;
            m_snap[i] = slot_in_p[i];
         end
      end
      @(posedge clock);
      #1;
      check("rvalid", 32'(rvalid), 32'(m_rvalid));
      check("data_out", data_out, m_rdata);
      check("ctrl_wstrobe", ctrl_wstrobe, m_strobe);
      check("slot_ctrl", slot_ctrl_p[sl], m_ctrl[sl]);
   endtask

   // Reset with a read request held through the reset edge.
   task automatic do_reset();
      reset   = 1'b1;
      rden    = 1'b1;
      address = 13'h1083;
      wren    = 1'b0;
      snap    = 1'b0;
      @(posedge clock);
      #1;
      model_clear();
      reset = 1'b0;
      rden  = 1'b0;
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_wstrobe", ctrl_wstrobe, 32'd0);
   endtask

   initial begin
      logic [12:0] ra;
      logic [4:0]  rs;
      logic [4:0]  ro;
      reset     = 1'b0;
      address   = '0;
      data_in   = '0;
      wren      = 1'b0;
      rden      = 1'b0;
      snap      = 1'b0;
      slot_in_p = '0;
      dmem_q    = '0;
      model_clear();
      @(posedge clock);
      #1;
      do_reset();

      step(13'h1203, 0, 0, 1, 0);
      check("tp_rd_ctrl4", data_out, 32'h0);
      check("tp_rd_ctrl4_v", 32'(rvalid), 32'd1);

      step(13'h1083, 32'h016000FA, 1, 1, 0);
      check("tp_wr_rd_same", data_out, 32'h0);
      check("tp_strobe", ctrl_wstrobe, 32'h2);
      check("tp_ctrl1", slot_ctrl_p[1], 32'h016000FA);
      step(13'h1083, 0, 0, 1, 0);
      check("tp_rd_ctrl1", data_out, 32'h016000FA);
      check("tp_strobe_off", ctrl_wstrobe, 32'h0);

      slot_in_p[0] = 32'h02A900FA;
      step(13'h0000, 0, 0, 0, 1);
      step(13'h1000, 0, 0, 1, 0);
      check("tp_snap0", data_out, 32'h02A900FA);
      step(13'h1002, 0, 0, 1, 0);
      check("tp_stat1", data_out, 32'h1);
      step(13'h1002, 0, 0, 1, 0);
      check("tp_stat_clr", data_out, 32'h0);

      slot_in_p[0] = 32'h1;
      step(13'h0000, 0, 0, 0, 1);
      slot_in_p[0] = 32'h2;
      step(13'h0000, 0, 0, 0, 1);
      step(13'h1002, 0, 0, 1, 0);
      check("tp_overrun", data_out, 32'h3);

      slot_in_p[0] = 32'h5;
      step(13'h0000, 0, 0, 0, 1);
      slot_in_p[0] = 32'h6;
      step(13'h1002, 0, 0, 1, 1);
      check("tp_race_pre", data_out, 32'h1);
      step(13'h1002, 0, 0, 1, 0);
      check("tp_race_set", data_out, 32'h1);

      dmem_q = 32'hDEADBEEF;
      step(13'h0005, 32'h12345678, 1, 0, 0);
      step(13'h0005, 0, 0, 1, 0);
      check("tp_dmem_rd", data_out, 32'hDEADBEEF);

      step(13'h1001, 32'hFFFFFFFF, 1, 0, 0);
      step(13'h1010, 32'hFFFFFFFF, 1, 0, 0);
      check("tp_hole_nostrobe", ctrl_wstrobe, 32'h0);
      step(13'h1010, 0, 0, 1, 0);
      check("tp_hole_rd", data_out, 32'h0);

      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 2) == 0) slot_in_p[$urandom_range(0, 3)] = $urandom_range(0, 3);
         if ($urandom_range(0, 15) == 0) slot_in_p[$urandom_range(0, NS-1)] = $urandom;
         dmem_q = $urandom;
         rs = ($urandom_range(0, 7) < 6) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         ro = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         ra = {($urandom_range(0, 7) != 0), rs, ro, 2'($urandom)};
         step(ra, $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 4) == 0));
      end
      for (int i = 0; i < NS; i++) check("sweep_ctrl", slot_ctrl_p[i], m_ctrl[i]);

      step(13'h1083, 0, 0, 1, 0);
      check("pre_rst_rvalid", 32'(rvalid), 32'd1);
      do_reset();
      step(13'h0000, 0, 0, 0, 0);
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
      step(13'h1002, 0, 0, 1, 0);
      check("post_rst_stat", data_out, 32'h0);
      step(13'h1000, 0, 0, 1, 0);
      check("post_rst_snap", data_out, 32'h0);
      for (int i = 0; i < NS; i++) check("post_rst_ctrl", slot_ctrl_p[i], 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
